uart_rx_sequencer: RTL and testbench
====================================

// Module: uart_rx_sequencer
// PURPOSE
//  Sequences one serial receive frame (1 start, DATA_BITS data LSB-first, 1 stop) from an
//  oversampled line. Owns start detection, mid-bit sampling, bit counting, shift-in and the
//  char_ready/char_read handshake that feeds the game-message decoder.
//  Replaces the free-running bit-count-complete scheme with a framed, error-checked controller.
// PARAMETERS
//  OVERSAMPLE  16  clk cycles per serial bit; even, >=4
//  DATA_BITS   8   data bits per frame, 5..8
// PORTS
//  clk         in   1          single system clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  serial_in   in   1          raw receive line, idle high, asynchronous to clk
//  char_read   in   1          1-cycle pulse: consumer has taken rx_data
//  rx_data     out  DATA_BITS  last received character, LSB = first data bit
//  char_ready  out  1          rx_data valid and unread
//  frame_err   out  1          stop bit of the last frame sampled low
//  overrun     out  1          sticky: frame completed while char_ready was already 1
//  busy        out  1          1 in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; rx_data=0; char_ready/frame_err/overrun/busy=0;
//    2-flop synchroniser on serial_in preset to 1. All other logic runs on clk only.
//  - tick counter 0..OVERSAMPLE-1, bit counter 0..DATA_BITS-1; both cleared on state entry.
//  - States:
//    IDLE   : synced line==0 -> START.
//    START  : at tick==OVERSAMPLE/2-1 sample line; 1 -> IDLE (glitch, nothing reported);
//             0 -> DATA, tick=0. All later samples therefore fall at bit centres.
//    DATA   : at tick==OVERSAMPLE-1 shift sample into MSB of shift reg (right shift), bit++;
//             after bit DATA_BITS-1 -> STOP (or PARITY when enabled).
//    STOP   : at tick==OVERSAMPLE-1 sample; rx_data<=shift reg, char_ready<=1,
//             frame_err<=~sample; sample==1 -> IDLE, sample==0 -> BREAK.
//    BREAK  : wait for synced line==1 -> IDLE (no start detection while line held low).
//  - Latency: char_ready rises on the clk edge after the stop-bit sample, i.e. start edge
//    + 2 (sync) + (DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2 cycles.
//  - Handshake: char_read clears char_ready next edge. If char_read coincides with frame
//    completion, the new frame wins: char_ready stays 1, overrun not set.
//  - Overrun: completion with char_ready==1 and no char_read -> overrun<=1, rx_data
//    overwritten with newest frame. overrun cleared only by char_read (or reset).
//  - frame_err is updated per frame (not sticky); stays valid while char_ready==1.
//  - char_read while char_ready==0: ignored. Never affects the receive FSM.
//  - Reset mid-frame: frame discarded, outputs return to reset values immediately.
// CONFIGURATION
//  PARITY_CHECK_EN defined: PARITY state inserted between DATA and STOP; one even-parity bit
//   sampled at its centre; output parity_err (1 bit, reset 0) <= (^shift reg)^sample, set
//   with char_ready; frame length DATA_BITS+3 bits.
//  Undefined: no PARITY state, no parity_err port; frame is DATA_BITS+2 bits.
// TESTING (OVERSAMPLE=16, DATA_BITS=8, parity off unless stated)
//  1 Frame 0x5A, stop=1 -> rx_data=0x5A, char_ready=1, frame_err=0, overrun=0, busy back to 0.
//  2 8-cycle low glitch on idle line -> START aborts to IDLE, char_ready stays 0, no data.
//  3 Two frames 0x11 then 0x22, no char_read -> rx_data=0x22, overrun=1; char_read -> both 0.
//  4 Frame 0xA5 with stop=0, line low 40 more bit times -> frame_err=1, rx_data=0xA5,
//    no new frame until line high; next frame 0x3C received cleanly, frame_err=0.
//  5 char_read pulsed on exact completion cycle of 2nd frame -> char_ready=1, overrun=0.
//  6 PARITY_CHECK_EN, 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> 0.
//    Also: rst_n low mid-DATA -> all outputs 0, next full frame received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// Receive-side bundle between the UART frame sequencer (slave) and its line/consumer driver (master).
// parity_err exists only when PARITY_CHECK_EN is defined.
interface uart_rx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic                 char_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 char_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
`ifdef PARITY_CHECK_EN
    logic                 parity_err;
`endif

    modport master (
`ifdef PARITY_CHECK_EN
        input  parity_err,
`endif
        output serial_in,
        output char_read,
        input  rx_data,
        input  char_ready,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
`ifdef PARITY_CHECK_EN
        output parity_err,
`endif
        input  serial_in,
        input  char_read,
        output rx_data,
        output char_ready,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// Framed UART receiver: start/mid-bit/stop sequencing; PARITY_CHECK_EN inserts an even-parity bit.
// Latency: char_ready rises 2 + (DATA_BITS+1)*OVERSAMPLE + OVERSAMPLE/2 cycles after the start edge.
// Backpressure: none on the line; an unread char is overwritten and flagged via sticky overrun.
module uart_rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_rx_sequencer_if.slave bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_CHECK_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 char_ready_q, char_ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy;
    logic                 line;
    logic                 tick_end;
    logic                 frame_done;
`ifdef PARITY_CHECK_EN
    logic                 par_smp_q, par_smp_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign line     = sync_q[1];
    assign tick_end = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!line) state_d = S_START;
            end
            S_START: begin
                if (tick_q == TICK_MID) state_d = line ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick_end && (bitcnt_q == BIT_LAST)) begin
`ifdef PARITY_CHECK_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (tick_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick_end) state_d = line ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync_d       = {sync_q[0], bus.serial_in};
        busy         = (state_q != S_IDLE);
        frame_done   = (state_q == S_STOP) && tick_end;
        tick_d       = tick_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        char_ready_d = char_ready_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef PARITY_CHECK_EN
        par_smp_d    = par_smp_q;
        parity_err_d = parity_err_q;
`endif

        // Counters restart on every state entry; IDLE/BREAK never advance them.
        if (state_d != state_q) begin
            tick_d   = '0;
            bitcnt_d = '0;
        end else if (state_q != S_IDLE && state_q != S_BREAK) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end

        if ((state_q == S_DATA) && tick_end) begin
            shift_d = {line, shift_q[DATA_BITS-1:1]};
            if (state_d == S_DATA) bitcnt_d = bitcnt_q + 1'b1;
        end

`ifdef PARITY_CHECK_EN
        if ((state_q == S_PARITY) && tick_end) par_smp_d = line;
`endif

        if (frame_done) begin
            rx_data_d    = shift_q;
            char_ready_d = 1'b1;
            frame_err_d  = ~line;
            // A read landing on the completion edge consumed the old char, so it is not lost.
            overrun_d    = ~bus.char_read & (overrun_q | char_ready_q);
`ifdef PARITY_CHECK_EN
            parity_err_d = (^shift_q) ^ par_smp_q;
`endif
        end else if (bus.char_read) begin
            char_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            tick_q       <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            char_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_smp_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            tick_q       <= tick_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            char_ready_q <= char_ready_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef PARITY_CHECK_EN
            par_smp_q    <= par_smp_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.char_ready = char_ready_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: directed scenarios plus randomized frames against a frame-level model.
// Define PARITY_CHECK_EN for both bench and RTL to exercise the parity build.
module tb_uart_rx_sequencer;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef PARITY_CHECK_EN
    localparam int LAT = 2 + (DB + 2) * OS + OS / 2;
`else
    localparam int LAT = 2 + (DB + 1) * OS + OS / 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_sequencer_if #(.DATA_BITS(DB)) bus ();

    uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic cr_prev = 1'b0;

    // Frame-level expectation of the visible outputs.
    logic [DB-1:0] m_data = '0;
    logic m_ready = 1'b0;
    logic m_ferr = 1'b0;
    logic m_ovr = 1'b0;
`ifdef PARITY_CHECK_EN
    logic m_perr = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.char_ready && !cr_prev) rise_cyc = cyc;
        cr_prev = bus.char_ready;
    end

    function automatic logic [DB+3:0] outs();
        return {bus.rx_data, bus.char_ready, bus.frame_err, bus.overrun, bus.busy};
    endfunction

    function automatic logic [DB+3:0] exp_outs(input logic busy_e);
        return {m_data, m_ready, m_ferr, m_ovr, busy_e};
    endfunction

    task automatic model_complete(input logic [DB-1:0] d, input logic stop_b, input logic par_b,
                                  input logic read_same);
        if (read_same) m_ovr = 1'b0;
        else if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = d;
        m_ferr  = ~stop_b;
`ifdef PARITY_CHECK_EN
        m_perr  = (^d) ^ par_b;
`else
        if (par_b === 1'bx) m_ferr = m_ferr;
`endif
    endtask

    task automatic drive_bit(input logic b);
        bus.serial_in = b;
        repeat (OS) @(negedge clk);
    endtask

    // Called at a falling edge; the first rising edge after the call sees the start bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        rise_cyc  = -1;
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef PARITY_CHECK_EN
        drive_bit(par_b);
`else
        if (par_b === 1'bx) bus.serial_in = 1'b1;
`endif
        drive_bit(stop_b);
    endtask

    task automatic pulse_read();
        bus.char_read = 1'b1;
        @(negedge clk);
        bus.char_read = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic test_reset();
        logic [DB+3:0] z;
        z = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== z) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", outs(), z);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (outs() !== z) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", outs(), z);
        end
    endtask

    task automatic test_single_frame();
        send_frame(8'h5A, 1'b1, ^8'h5A);
        model_complete(8'h5A, 1'b1, ^8'h5A, 1'b0);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL frame_5a got=%h exp=%h", outs(), exp_outs(1'b0));
        end
        checks++;
        if (rise_cyc - start_cyc !== LAT) begin
            errors++;
            $display("FAIL latency got=%0d exp=%0d", rise_cyc - start_cyc, LAT);
        end
        pulse_read();
        @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL read_clear got=%h exp=%h", outs(), exp_outs(1'b0));
        end
    endtask

    task automatic test_glitch();
        bus.serial_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got=%b exp=1", bus.busy);
        end
        repeat (4) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL glitch_abort got=%h exp=%h", outs(), exp_outs(1'b0));
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, ^8'h11);
        model_complete(8'h11, 1'b1, ^8'h11, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22);
        model_complete(8'h22, 1'b1, ^8'h22, 1'b0);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL overrun_set got=%h exp=%h", outs(), exp_outs(1'b0));
        end
        pulse_read();
        @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL overrun_clear got=%h exp=%h", outs(), exp_outs(1'b0));
        end
    endtask

    task automatic test_break();
        send_frame(8'hA5, 1'b0, ^8'hA5);
        model_complete(8'hA5, 1'b0, ^8'hA5, 1'b0);
        checks++;
        if (outs() !== exp_outs(1'b1)) begin
            errors++;
            $display("FAIL break_frame_err got=%h exp=%h", outs(), exp_outs(1'b1));
        end
        repeat (40 * OS) @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b1)) begin
            errors++;
            $display("FAIL break_hold got=%h exp=%h", outs(), exp_outs(1'b1));
        end
        pulse_read();
        @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b1)) begin
            errors++;
            $display("FAIL break_read got=%h exp=%h", outs(), exp_outs(1'b1));
        end
        bus.serial_in = 1'b1;
        repeat (OS) @(negedge clk);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL break_exit got=%h exp=%h", outs(), exp_outs(1'b0));
        end
        send_frame(8'h3C, 1'b1, ^8'h3C);
        model_complete(8'h3C, 1'b1, ^8'h3C, 1'b0);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL after_break got=%h exp=%h", outs(), exp_outs(1'b0));
        end
    endtask

    task automatic test_read_coincide();
        pulse_read();
        send_frame(8'h01, 1'b1, ^8'h01);
        model_complete(8'h01, 1'b1, ^8'h01, 1'b0);
        fork
            send_frame(8'h02, 1'b1, ^8'h02);
            begin
                repeat (LAT) @(negedge clk);
                bus.char_read = 1'b1;
                @(negedge clk);
                bus.char_read = 1'b0;
            end
        join
        model_complete(8'h02, 1'b1, ^8'h02, 1'b1);
        checks++;
        if (outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL read_coincide got=%h exp=%h", outs(), exp_outs(1'b0));
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        pulse_read();
        send_frame(8'h07, 1'b1, 1'b0);
        model_complete(8'h07, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.parity_err !== m_perr || outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL parity_bad got=%b/%h exp=%b/%h", bus.parity_err, outs(), m_perr, exp_outs(1'b0));
        end
        send_frame(8'h07, 1'b1, 1'b1);
        model_complete(8'h07, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.parity_err !== m_perr || outs() !== exp_outs(1'b0)) begin
            errors++;
            $display("FAIL parity_good got=%b/%h exp=%b/%h", bus.parity_err, outs(), m_perr, exp_outs(1'b0));
        end
    endtask
`endif

    task automatic test_random();
        logic [DB-1:0] d;
        logic pb;
        logic was_ready;
        for (int n = 0; n < 24; n++) begin
            d  = DB'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            was_ready = m_ready;
            send_frame(d, 1'b1, pb);
            model_complete(d, 1'b1, pb, 1'b0);
            checks++;
            if (outs() !== exp_outs(1'b0)) begin
                errors++;
                $display("FAIL rand_frame[%0d] got=%h exp=%h", n, outs(), exp_outs(1'b0));
            end
`ifdef PARITY_CHECK_EN
            checks++;
            if (bus.parity_err !== m_perr) begin
                errors++;
                $display("FAIL rand_parity[%0d] got=%b exp=%b", n, bus.parity_err, m_perr);
            end
`endif
            if (!was_ready) begin
                checks++;
                if (rise_cyc - start_cyc !== LAT) begin
                    errors++;
                    $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, rise_cyc - start_cyc, LAT);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                checks++;
                if (outs() !== exp_outs(1'b0)) begin
                    errors++;
                    $display("FAIL rand_read[%0d] got=%h exp=%h", n, outs(), exp_outs(1'b0));
                end
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DB+3:0] z;
        z = '0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== z) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", outs(), z);
        end
        m_data  = '0;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
`ifdef PARITY_CHECK_EN
        m_perr  = 1'b0;
`endif
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h96, 1'b1, ^8'h96);
        model_complete(8'h96, 1'b1, ^8'h96, 1'b0);
        checks++;
        if (outs() !== exp_outs(1'b0) || rise_cyc - start_cyc !== LAT) begin
            errors++;
            $display("FAIL after_reset got=%h/%0d exp=%h/%0d", outs(), rise_cyc - start_cyc,
                     exp_outs(1'b0), LAT);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.serial_in = 1'b1;
        bus.char_read = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_overrun();
        test_break();
        test_read_coincide();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
